// File: rtl/neuron_group_mac.sv
// Eight-neuron sign-magnitude MAC group: accumulates NUM_LEVELS 8-input slices per neuron, then adds bias and saturates.
// Optional macro NGM_RELU_EN clamps negative results to zero.
module neuron_group_mac #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = 3,
  parameter int GP_W       = 2,
  parameter int SHIFT      = 0,
  parameter int ACC_W      = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [GP_W-1:0]    gp_i,
  output logic [GP_W-1:0]    gp_o,
  output logic [LEVEL_W-1:0] level_o,
  input  logic [511:0]       w_in,
  input  logic [63:0]        x_in,
  input  logic [63:0]        b_in,
  output logic               busy,
  output logic               out_valid,
  output logic [63:0]        out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  state_t                   state, state_nx;
  logic                     vpipe;
  logic signed [ACC_W-1:0]  acc       [8];
  logic signed [ACC_W-1:0]  slice_sum [8];
  logic [63:0]              res_bus;

  function automatic logic signed [ACC_W-1:0] sm_prod(input logic [7:0] w, input logic [7:0] x);
    logic [13:0]             mag;
    logic signed [ACC_W-1:0] m;
    mag = w[6:0] * x[6:0];
    m   = ACC_W'(mag);
    return (w[7] ^ x[7]) ? -m : m;
  endfunction

  function automatic logic signed [ACC_W:0] sm_to_signed(input logic [7:0] b);
    logic signed [ACC_W:0] m;
    m = (ACC_W+1)'(b[6:0]);
    return b[7] ? -m : m;
  endfunction

  function automatic logic [7:0] sm_sat(input logic signed [ACC_W:0] r);
    logic signed [ACC_W:0] neg;
    logic [7:0]            y;
    neg = -r;
`ifdef NGM_RELU_EN
    if (r < 0)        y = 8'h00;
    else if (r > 127) y = 8'h7F;
    else              y = {1'b0, r[6:0]};
`else
    if (r >= 0) begin
      if (r > 127) y = 8'h7F;
      else         y = {1'b0, r[6:0]};
    end else begin
      if (neg > 127) y = 8'hFF;
      else           y = {1'b1, neg[6:0]};
    end
`endif
    return y;
  endfunction

  always_comb begin
    logic signed [ACC_W-1:0] sh;
    logic signed [ACC_W:0]   r;
    res_bus = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      slice_sum[n] = '0;
      for (int unsigned k = 0; k < 8; k++)
        slice_sum[n] = slice_sum[n] + sm_prod(w_in[(8*n+k)*8 +: 8], x_in[k*8 +: 8]);
      sh = acc[n] >>> SHIFT;
      r  = {sh[ACC_W-1], sh} + sm_to_signed(b_in[n*8 +: 8]);
      res_bus[n*8 +: 8] = sm_sat(r);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (level_o == LAST_LEVEL) state_nx = DRAIN;
      DRAIN:   state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory data lags the issued level by one edge, so vpipe marks edges carrying a valid slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gp_o      <= '0;
      level_o   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      vpipe     <= 1'b0;
      for (int unsigned n = 0; n < 8; n++) acc[n] <= '0;
    end else begin
      out_valid <= 1'b0;
      vpipe     <= (state == RUN);
      if (vpipe)
        for (int unsigned n = 0; n < 8; n++) acc[n] <= acc[n] + slice_sum[n];
      case (state)
        IDLE: if (start) begin
          gp_o    <= gp_i;
          level_o <= '0;
          busy    <= 1'b1;
          for (int unsigned n = 0; n < 8; n++) acc[n] <= '0;
        end
        RUN: if (level_o != LAST_LEVEL) level_o <= level_o + 1'b1;
        FINISH: begin
          out       <= res_bus;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/neuron_group_mac.md
NEURON_GROUP_MAC -- requirements
Module: neuron_group_mac

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 8, meaning the number of 8-input slices accumulated per result (8 for layer 0, 4 for layer 1).
REQ-002 SHALL have parameter LEVEL_W, default 3, meaning the width of level_o.
REQ-003 SHALL have parameter GP_W, default 2, meaning the width of gp_i and gp_o.
REQ-004 SHALL have parameter SHIFT, default 0, meaning the arithmetic right shift applied to the accumulator before the bias add.
REQ-005 SHALL have parameter ACC_W, default 24, meaning the signed accumulator width.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  request to compute one neuron group.
REQ-009 gp_i  in  GP_W  neuron group index to compute.
REQ-010 gp_o  out  GP_W  group index driven to the weight and bias memories.
REQ-011 level_o  out  LEVEL_W  level index driven to the weight and input memories.
REQ-012 w_in  in  512  weight slice; byte (8n+k) is the weight from input k to neuron n.
REQ-013 x_in  in  64  input slice; byte k is input k.
REQ-014 b_in  in  64  bias; byte n is the bias for neuron n.
REQ-015 busy  out  1  high from start acceptance until out_valid.
REQ-016 out_valid  out  1  one-cycle pulse marking a valid out.
REQ-017 out  out  64  byte n is the result for neuron n, in sign-magnitude format.

Function
REQ-018 All data bytes SHALL be sign-magnitude: bit 7 is the sign and bits 6:0 are the magnitude; 0x80 SHALL be treated as zero.
REQ-019 The memories SHALL be treated as returning data one clock edge after sampling gp_o/level_o, with registered outputs.
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN and FINISH.
REQ-021 IDLE: on start=1, latch gp_i into gp_o, clear all eight accumulators, set level_o=0, assert busy and go to RUN.
REQ-022 RUN: increment level_o each cycle; at level_o=NUM_LEVELS-1 go to DRAIN; level_o SHALL NOT wrap past NUM_LEVELS-1 while busy.
REQ-023 A one-bit valid pipe SHALL track issued levels; each edge where it is set, every neuron n SHALL add the signed sum of products w(8n+k)*x(k), k=0..7, into acc[n].
REQ-024 Each product SHALL have magnitude w[6:0]*x[6:0] (14 bits) and sign w[7]^x[7]; a zero magnitude SHALL contribute 0 regardless of sign.
REQ-025 DRAIN SHALL last one cycle and absorb the final level's accumulation, then go to FINISH.
REQ-026 FINISH: compute r = (acc[n] >>> SHIFT) + signed(b_in byte n), convert to sign-magnitude with saturation to magnitude 127, register the result into out, pulse out_valid, deassert busy and return to IDLE.
REQ-027 With start sampled at edge 0, out_valid SHALL be high for exactly the cycle following edge NUM_LEVELS+2.
REQ-028 start SHALL be ignored while not in IDLE; a start coincident with out_valid SHALL be accepted.
REQ-029 out SHALL hold its value until the next FINISH; gp_o SHALL be stable while busy.
REQ-030 The accumulators SHALL NOT overflow for NUM_LEVELS≤8 with ACC_W=24; no wrap handling is required.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, busy=0, out_valid=0, out=0, level_o=0, gp_o=0, accumulators and the valid pipe cleared.
REQ-032 Reset mid-operation SHALL abort the operation with no out_valid, and the next start SHALL produce a clean result.

Configuration
REQ-033 When macro NGM_RELU_EN is defined, any r<0 SHALL produce 0x00, with positive saturation to 0x7F.
REQ-034 When NGM_RELU_EN is undefined, the result SHALL be signed with saturation to 0x7F / 0xFF.

Verification
REQ-035 NUM_LEVELS=8, all w=0x01, all x=0x01, b=0 -> every out byte 0x40; out_valid pulses after edge 10; busy high edges 0..10.
REQ-036 All w=0x81, all x=0x02, b=0x05 -> r=-123; out bytes 0xFB without NGM_RELU_EN, 0x00 with it.
REQ-037 All w=0x7F, all x=0x7F, b=0x7F -> every out byte 0x7F; with w=0xFF and no ReLU -> every out byte 0xFF.
REQ-038 x=0x80 in every byte, w=0x55, b=0x03 -> every out byte 0x03.
REQ-039 start pulsed again at edges 3 and 5 -> ignored, level_o sequence 0..7 unchanged; start on the out_valid cycle -> a new run begins.
REQ-040 rst asserted while level_o=4 -> outputs immediately at reset values; a following start with the REQ-035 stimulus -> out bytes 0x40.
